store_buffer: RTL and testbench

- Word-store FIFO between the MEM-stage address/data path and DataMem.
- Stores retire from the pipeline into the buffer in one cycle, then drain to DataMem one per cycle whenever the single DataMem address port is not needed by a load.
- Loads search the buffer:
  - exact-address hit: forwarded from the youngest matching entry;
  - partial byte overlap: stalled until the overlapping entries drain.

---
 rtl/store_buffer.sv | 133 +++++++++++++
 tb/tb_store_buffer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: word-store FIFO between the MEM stage and DataMem.
// Stores retire into a circular buffer and drain one per cycle whenever the
// single DataMem port is not taken by a missing load. Loads search every
// pending entry: partial byte overlaps stall, exact hits may be forwarded.
// Optional feature macro: STORE_BUF_FWD_EN (youngest exact-hit forwarding).
// Without it, any hit or overlap stalls the load until those entries drain.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     st_valid,
   input  logic [ADDR_W-1:0]        st_addr,
   input  logic [DATA_W-1:0]        st_data,
   output logic                     st_ready,
   input  logic                     ld_valid,
   input  logic [ADDR_W-1:0]        ld_addr,
   output logic [DATA_W-1:0]        ld_data,
   output logic                     ld_stall,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     sb_empty,
   output logic [$clog2(DEPTH):0]   sb_count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [PTR_W:0]    count_q, count_d;

   logic [DEPTH-1:0]  valid_w;
   logic [DEPTH-1:0]  hit_w;
   logic [DEPTH-1:0]  ovl_w;
   logic              any_hit, any_ovl, miss, drain, push;

   // Per-entry search: an entry is live when its distance from head is below
   // count; overlap uses wrap-around differences in both directions so that
   // byte ranges straddling the top of the address space are still caught.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [PTR_W-1:0]  age;
         logic [ADDR_W-1:0] diff_fwd, diff_bwd;
         assign age          = PTR_W'(gi) - head_q;
         assign valid_w[gi]  = {1'b0, age} < count_q;
         assign diff_fwd     = ld_addr - addr_q[gi];
         assign diff_bwd     = addr_q[gi] - ld_addr;
         assign hit_w[gi]    = valid_w[gi] && (addr_q[gi] == ld_addr);
         assign ovl_w[gi]    = valid_w[gi] && (addr_q[gi] != ld_addr) &&
                               ((diff_fwd < ADDR_W'(4)) || (diff_bwd < ADDR_W'(4)));
      end
   endgenerate

   assign any_hit  = |hit_w;
   assign any_ovl  = |ovl_w;
   assign miss     = !any_hit && !any_ovl;
   assign st_ready = (count_q != (PTR_W+1)'(DEPTH));
   assign push     = st_valid && st_ready;
   // A missing load owns the DataMem port; hit or stalled loads leave it free.
   assign drain    = (count_q != '0) && !(ld_valid && miss);

`ifdef STORE_BUF_FWD_EN
   logic [DATA_W-1:0] fwd_data;

   // Walk oldest to youngest so the last match written is the youngest one.
   always_comb begin
      fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (hit_w[head_q + PTR_W'(k)]) begin
            fwd_data = data_q[head_q + PTR_W'(k)];
         end
      end
   end

   assign ld_stall = ld_valid && any_ovl;
   assign ld_data  = (any_hit && !any_ovl) ? fwd_data : mem_rdata;
`else
   assign ld_stall = ld_valid && (any_hit || any_ovl);
   assign ld_data  = mem_rdata;
`endif

   assign mem_we    = drain;
   assign mem_addr  = (drain || !ld_valid) ? addr_q[head_q] : ld_addr;
   assign mem_wdata = data_q[head_q];
   assign sb_empty  = (count_q == '0);
   assign sb_count  = count_q;

   // Pointer and occupancy next state from push/drain handshakes.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (drain) begin
         head_d = head_q + 1'b1;
      end
      if (push) begin
         tail_d = tail_q + 1'b1;
      end
      case ({push, drain})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer/count registers; reset discards every pending store.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are meaningless until counted as live.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= st_addr;
         data_q[tail_q] <= st_data;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios followed by random traffic, all checked
// against a queue-based model of the pending stores and a hashed DataMem.
module tb_store_buffer;

   localparam int DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid;
   logic [31:0] st_addr, st_data;
   logic        st_ready;
   logic        ld_valid;
   logic [31:0] ld_addr, ld_data;
   logic        ld_stall;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        sb_empty;
   logic [2:0]  sb_count;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   entry_t mq[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc    = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   assign mem_rdata = hash(mem_addr);

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .sb_empty(sb_empty), .sb_count(sb_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // One clock of stimulus: drive, compare against the model, then advance it.
   task automatic step(input logic rn, input logic sv, input logic [31:0] sa,
                       input logic [31:0] sd, input logic lv, input logic [31:0] la);
      logic        hit, ovl, e_stall, e_drain, e_ready;
      logic [31:0] yd, d1, d2;
      rst_n = rn; st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
      #2;
      hit = 1'b0; ovl = 1'b0; yd = '0;
      foreach (mq[i]) begin
         d1 = la - mq[i].addr;
         d2 = mq[i].addr - la;
         if (mq[i].addr == la) begin
            hit = 1'b1;
            yd  = mq[i].data;
         end else if (d1 < 32'd4 || d2 < 32'd4) begin
            ovl = 1'b1;
         end
      end
      e_ready = (mq.size() != DEPTH);
      e_stall = lv && (ovl || (!FWD && hit));
      e_drain = (mq.size() != 0) && !(lv && !hit && !ovl);
      check("st_ready", 32'(st_ready), 32'(e_ready));
      check("sb_count", 32'(sb_count), 32'(mq.size()));
      check("sb_empty", 32'(sb_empty), 32'(mq.size() == 0));
      check("ld_stall", 32'(ld_stall), 32'(e_stall));
      check("mem_we", 32'(mem_we), 32'(e_drain));
      if (e_drain) begin
         check("drain_addr", mem_addr, mq[0].addr);
         check("drain_data", mem_wdata, mq[0].data);
      end else if (lv) begin
         check("load_port_addr", mem_addr, la);
      end
      if (lv && !e_stall) begin
         check("ld_data", ld_data, hit ? yd : hash(la));
      end
      $display("cyc %0d rst_n=%0b st=%0b@%h ld=%0b@%h cnt=%0d we=%0b stall=%0b",
               cyc, rn, sv, sa, lv, la, mq.size(), e_drain, e_stall);
      @(posedge clk);
      cyc++;
      if (!rn) begin
         mq.delete();
      end else begin
         if (e_drain) void'(mq.pop_front());
         if (sv && e_ready) mq.push_back('{addr: sa, data: sd});
      end
      #1;
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 7));
         1:       return 32'h40 + 32'($urandom_range(0, 12));
         default: return 32'h40 + 32'(4 * $urandom_range(0, 3));
      endcase
   endfunction

   initial begin
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // Reset mid-drain; the missing load keeps 0x14 off the port in the reset cycle.
      step(1, 1, 32'h10, 32'hAAAA_0001, 0, 0);
      step(1, 1, 32'h14, 32'hAAAA_0002, 0, 0);
      step(0, 0, 0, 0, 1, 32'h100);
      step(1, 0, 0, 0, 0, 0);

      // Fill to full while drains are blocked, hold a fifth store, then drain.
      for (int i = 0; i < 4; i++) step(1, 1, 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1, 32'h300);
      step(1, 1, 32'h10, 32'hC0DE_0004, 1, 32'h300);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);

      // Youngest forward.
      step(1, 1, 32'h20, 32'h1111_1111, 1, 32'h100);
      step(1, 1, 32'h20, 32'h2222_2222, 1, 32'h100);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 32'h20);

      // Partial overlap.
      step(1, 1, 32'h40, 32'hDEAD_BEEF, 1, 32'h100);
      step(1, 0, 0, 0, 1, 32'h42);
      step(1, 0, 0, 0, 1, 32'h42);

      // Port conflict.
      step(1, 1, 32'h50, 32'h5000_0001, 1, 32'h200);
      step(1, 1, 32'h54, 32'h5000_0002, 1, 32'h200);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 32'h200);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);

      // Simultaneous push and drain at count 2.
      step(1, 1, 32'h60, 32'h6000_0000, 1, 32'h200);
      step(1, 1, 32'h64, 32'h6000_0001, 1, 32'h200);
      for (int i = 0; i < 5; i++) step(1, 1, 32'h68 + 32'(4 * i), 32'h6000_0002 + 32'(i), 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);

      // Random traffic over a small, overlap-prone address pool.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), pick_addr(), $urandom(),
              $urandom_range(0, 2) != 0, pick_addr());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
